dht11_responder: RTL and testbench

- Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol.
- Detects a host start pulse on the open-drain data line, then drives the ACK and a 40-bit frame built from the input measurement registers.
- Used as a bench and board-level stand-in for the physical sensor, so the host-side reader and the UART reporting path can be tested without hardware.

---
 rtl/dht11_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dht11_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// dht11_responder: responder (sensor) side of the single-wire DHT11 protocol.
// Waits for a long host low pulse on the open-drain line. It then answers with
// the ACK low/high pair and a 40-bit frame: hum_int, hum_dec, temp_int,
// temp_dec and an 8-bit additive checksum, each sent MSB first.
// The line is only ever pulled low or released; an external pull-up supplies
// the high level.
module dht11_responder #(
    parameter int CLK_PER_US    = 50,
    parameter int START_MIN_US  = 15000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_US        = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_US       = 26,
    parameter int BIT1_US       = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        data,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
);

    localparam int PRE_W = $clog2(CLK_PER_US + 1);
    localparam int LOW_W = $clog2(START_MIN_US + 1);
    localparam int US_W  = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REL = 3'd1,
        ACK_LO   = 3'd2,
        ACK_HI   = 3'd3,
        BIT_LO   = 3'd4,
        BIT_HI   = 3'd5,
        END_LO   = 3'd6
    } state_t;

    // Frame checksum: byte sum of the four measurement bytes, modulo 256.
    function automatic logic [7:0] checksum8(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        logic [7:0] sum_v;
        sum_v = a + b + c + d;
        return sum_v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             state_chg_s;
    logic             sync1_r;
    logic             sync_d_r;
    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [US_W-1:0]  us_r;
    logic [US_W-1:0]  phase_len_s;
    logic             phase_done_s;
    logic [LOW_W-1:0] low_cnt_r;
    logic             start_ok_s;
    logic [39:0]      shift_r;
    logic [5:0]       bit_cnt_r;
    logic             drive_low_r;
    logic             busy_r;
    logic             frame_done_r;

    assign tick_s      = (pre_r == PRE_W'(CLK_PER_US - 1));
    assign state_chg_s = (state_nxt_s != state_r);
    assign start_ok_s  = sync_d_r && enable && (low_cnt_r >= LOW_W'(START_MIN_US));

    // Two-flop synchronizer for the bus; the idle (pulled-up) level is the reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r  <= 1'b1;
            sync_d_r <= 1'b1;
        end else begin
            sync1_r  <= data;
            sync_d_r <= sync1_r;
        end
    end

    // Duration of the current timed phase in microseconds.
    always_comb begin
        phase_len_s = US_W'(1);
        case (state_r)
            WAIT_REL:        phase_len_s = US_W'(RESP_DELAY_US);
            ACK_LO, ACK_HI:  phase_len_s = US_W'(ACK_US);
            BIT_LO, END_LO:  phase_len_s = US_W'(BIT_LOW_US);
            BIT_HI: begin
                if (shift_r[39]) begin
                    phase_len_s = US_W'(BIT1_US);
                end else begin
                    phase_len_s = US_W'(BIT0_US);
                end
            end
            default:         phase_len_s = US_W'(1);
        endcase
        phase_done_s = tick_s && (us_r == (phase_len_s - US_W'(1)));
    end

    // Next-state logic; bus activity is only examined in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = WAIT_REL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_REL: begin
                if (phase_done_s) begin
                    state_nxt_s = ACK_LO;
                end else begin
                    state_nxt_s = WAIT_REL;
                end
            end
            ACK_LO: begin
                if (phase_done_s) begin
                    state_nxt_s = ACK_HI;
                end else begin
                    state_nxt_s = ACK_LO;
                end
            end
            ACK_HI: begin
                if (phase_done_s) begin
                    state_nxt_s = BIT_LO;
                end else begin
                    state_nxt_s = ACK_HI;
                end
            end
            BIT_LO: begin
                if (phase_done_s) begin
                    state_nxt_s = BIT_HI;
                end else begin
                    state_nxt_s = BIT_LO;
                end
            end
            BIT_HI: begin
                if (phase_done_s && (bit_cnt_r == 6'd39)) begin
                    state_nxt_s = END_LO;
                end else if (phase_done_s) begin
                    state_nxt_s = BIT_LO;
                end else begin
                    state_nxt_s = BIT_HI;
                end
            end
            END_LO: begin
                if (phase_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = END_LO;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Microsecond prescaler and per-phase microsecond counter, both restarted on every state entry.
    always_ff @(posedge clk) begin
        if (!rst_n || state_chg_s) begin
            pre_r <= '0;
            us_r  <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
            us_r  <= us_r + US_W'(1);
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Host low-time counter: runs only in IDLE while the bus is low, saturating at the start threshold.
    always_ff @(posedge clk) begin
        if (!rst_n || (state_r != IDLE) || sync_d_r) begin
            low_cnt_r <= '0;
        end else if (tick_s && (low_cnt_r < LOW_W'(START_MIN_US))) begin
            low_cnt_r <= low_cnt_r + LOW_W'(1);
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    // Frame shift register: loaded at start acceptance, shifted after each bit high phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else if ((state_r == IDLE) && start_ok_s) begin
            shift_r   <= {hum_int, hum_dec, temp_int, temp_dec,
                          checksum8(hum_int, hum_dec, temp_int, temp_dec)};
            bit_cnt_r <= '0;
        end else if ((state_r == BIT_HI) && phase_done_s) begin
            shift_r   <= {shift_r[38:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 6'd1;
        end else begin
            shift_r   <= shift_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drive_low_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            drive_low_r  <= (state_nxt_s == ACK_LO) || (state_nxt_s == BIT_LO) ||
                            (state_nxt_s == END_LO);
            busy_r       <= (state_nxt_s != IDLE);
            frame_done_r <= (state_r == END_LO) && phase_done_s;
        end
    end

    assign data       = drive_low_r ? 1'b0 : 1'bz;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder. The bench plays the host side of the bus. It
// records the line, busy and frame_done once per cycle and compares them with
// a waveform built from the protocol's phase list. It also decodes the
// recorded line back into bytes.
module tb_dht11_responder;

    localparam int CAP        = 5300;
    localparam int START_MIN  = 100;
    localparam int RESP_US    = 30;
    localparam int ACK_LEN    = 80;
    localparam int BITLO_LEN  = 50;
    localparam int BIT0_LEN   = 26;
    localparam int BIT1_LEN   = 70;
    localparam int SYNC_LAT   = 2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       host_low;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       frame_done;
    wire        data;

    pullup (data);
    assign data = host_low ? 1'b0 : 1'bz;

    dht11_responder #(
        .CLK_PER_US   (1),
        .START_MIN_US (START_MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .enable     (enable),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic       trace_d [CAP];
    logic       trace_b [CAP];
    logic       trace_f [CAP];
    logic       exp_d   [CAP];
    logic       exp_b   [CAP];
    logic       exp_f   [CAP];
    int         end_idx;
    int         hi_len  [40];
    logic [39:0] dec_bits;
    int         n_bits;
    logic [7:0] bytes_v [5];

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Build the five bytes (four inputs plus modular sum) and apply them to the DUT inputs.
    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
        bytes_v[0] = a; bytes_v[1] = b; bytes_v[2] = c; bytes_v[3] = d;
        bytes_v[4] = 8'((int'(a) + int'(b) + int'(c) + int'(d)) % 256);
    endtask

    task automatic put(inout int t, input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            exp_d[t + i] = lvl;
            exp_b[t + i] = 1'b1;
        end
        t = t + n;
    endtask

    task automatic build_idle();
        for (int i = 0; i < CAP; i++) begin
            exp_d[i] = 1'b1; exp_b[i] = 1'b0; exp_f[i] = 1'b0;
        end
        end_idx = -1;
    endtask

    // Expected waveform, sample 0 being the first cycle after the host releases the line.
    task automatic build_model();
        int t;
        logic [39:0] bits;
        bits = {bytes_v[0], bytes_v[1], bytes_v[2], bytes_v[3], bytes_v[4]};
        build_idle();
        t = SYNC_LAT;
        put(t, RESP_US, 1'b1);
        put(t, ACK_LEN, 1'b0);
        put(t, ACK_LEN, 1'b1);
        for (int k = 0; k < 40; k++) begin
            put(t, BITLO_LEN, 1'b0);
            put(t, bits[39 - k] ? BIT1_LEN : BIT0_LEN, 1'b1);
        end
        put(t, BITLO_LEN, 1'b0);
        exp_f[t] = 1'b1;
        end_idx  = t;
    endtask

    // Host start pulse followed by recording; optional input change, host glitch and reset.
    task automatic run_frame(input int low_us, input int poke_at, input int intf_at, input int rst_at);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_us) @(negedge clk);
        host_low = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            @(negedge clk);
            trace_d[i] = data;
            trace_b[i] = busy;
            trace_f[i] = frame_done;
            if (i == poke_at) begin
                hum_int = 8'($urandom); hum_dec = 8'($urandom);
                temp_int = 8'($urandom); temp_dec = 8'($urandom);
            end
            host_low = (intf_at >= 0) && (i >= intf_at) && (i < intf_at + 10);
            if (i == rst_at) begin
                rst_n = 1'b0;
            end else if ((rst_at >= 0) && (i == rst_at + 1)) begin
                rst_n = 1'b1;
            end
        end
    endtask

    function automatic int run_len(input int start, input logic lvl);
        int n;
        n = 0;
        while ((start + n < CAP) && (trace_d[start + n] === lvl)) n++;
        return n;
    endfunction

    // Decode the recorded line: skip the ACK low, then each low of >= 40 cycles precedes a data bit.
    task automatic decode_trace();
        int i;
        int r;
        int h;
        dec_bits = '0;
        n_bits   = 0;
        i        = 0;
        while ((i < CAP) && (trace_d[i] !== 1'b0)) i++;
        if (i < CAP) i = i + run_len(i, 1'b0);
        while ((i < CAP) && (n_bits < 40)) begin
            if (trace_d[i] === 1'b1) begin
                i = i + run_len(i, 1'b1);
            end else begin
                r = run_len(i, 1'b0);
                if (r == 0) r = 1;
                i = i + r;
                if (r >= 40) begin
                    h = run_len(i, 1'b1);
                    hi_len[n_bits] = h;
                    dec_bits = {dec_bits[38:0], (h > 48) ? 1'b1 : 1'b0};
                    n_bits++;
                    i = i + h;
                end
            end
        end
    endtask

    task automatic check_wave(input string tag);
        int md; int mb; int mf; int nf; int first_f;
        md = 0; mb = 0; mf = 0; nf = 0; first_f = -1;
        for (int i = 0; i < CAP; i++) begin
            if (trace_d[i] !== exp_d[i]) md++;
            if (trace_b[i] !== exp_b[i]) mb++;
            if (trace_f[i] !== exp_f[i]) mf++;
            if (trace_f[i] === 1'b1) begin
                nf++;
                if (first_f < 0) first_f = i;
            end
        end
        chk({tag, "_line_mismatches"}, md, 0);
        chk({tag, "_busy_mismatches"}, mb, 0);
        chk({tag, "_done_mismatches"}, mf, 0);
        chk({tag, "_done_count"}, nf, (end_idx >= 0) ? 1 : 0);
        chk({tag, "_done_index"}, first_f, end_idx);
    endtask

    task automatic check_bytes(input string tag);
        decode_trace();
        chk({tag, "_bit_count"}, n_bits, 40);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), dec_bits[39 - 8*k -: 8], bytes_v[k]);
        end
    endtask

    int rst_idx;

    initial begin
        rst_n = 1'b0; enable = 1'b1; host_low = 1'b0;
        hum_int = 8'd0; hum_dec = 8'd0; temp_int = 8'd0; temp_dec = 8'd0;
        repeat (5) @(negedge clk);
        chk("reset_data", data, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame.
        set_inputs(8'h37, 8'h00, 8'h19, 8'h00);
        chk("basic_checksum_model", bytes_v[4], 8'h50);
        build_model();
        run_frame(150, -1, -1, -1);
        check_wave("basic");
        check_bytes("basic");

        // Checksum wrap and bit high lengths.
        set_inputs(8'h80, 8'h80, 8'h80, 8'h80);
        build_model();
        run_frame(150, -1, -1, -1);
        check_wave("wrap");
        check_bytes("wrap");
        chk("wrap_bit0_high", hi_len[0], BIT1_LEN);
        chk("wrap_bit1_high", hi_len[1], BIT0_LEN);

        // Short start gets no answer; a following valid start does.
        build_idle();
        run_frame(60, -1, -1, -1);
        check_wave("short");
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        build_model();
        run_frame(150, -1, -1, -1);
        check_wave("after_short");
        check_bytes("after_short");

        // Disabled start ignored; inputs changed mid-frame do not reach the wire.
        enable = 1'b0;
        build_idle();
        run_frame(150, -1, -1, -1);
        check_wave("disabled");
        enable = 1'b1;
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        build_model();
        run_frame(150, 600, -1, -1);
        check_wave("latched");
        check_bytes("latched");

        // Reset during the low preamble of the 12th bit.
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        build_model();
        rst_idx = SYNC_LAT + RESP_US + 2 * ACK_LEN;
        for (int k = 0; k < 11; k++) begin
            rst_idx = rst_idx + BITLO_LEN + (dec_bits[0] === 1'bx ? 0 : 0) +
                      (({bytes_v[0], bytes_v[1], bytes_v[2], bytes_v[3], bytes_v[4]} >> (39 - k)) & 40'd1
                       ? BIT1_LEN : BIT0_LEN);
        end
        rst_idx = rst_idx + 20;
        for (int i = rst_idx + 1; i < CAP; i++) begin
            exp_d[i] = 1'b1; exp_b[i] = 1'b0; exp_f[i] = 1'b0;
        end
        end_idx = -1;
        run_frame(150, -1, -1, rst_idx);
        check_wave("reset_mid");
        chk("reset_mid_pre_line", trace_d[rst_idx], 0);
        chk("reset_mid_line", trace_d[rst_idx + 1], 1);
        chk("reset_mid_busy", trace_b[rst_idx + 1], 0);
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        build_model();
        run_frame(150, -1, -1, -1);
        check_wave("after_reset");
        check_bytes("after_reset");

        // Host glitch during ACK high is ignored.
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        build_model();
        for (int i = 131; i <= 140; i++) exp_d[i] = 1'b0;
        run_frame(150, -1, 130, -1);
        check_wave("glitch");
        check_bytes("glitch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
